// File: rtl/seg_p2s.sv
// seg_p2s: parallel-to-serial driver for the 7-segment shift-register chain.
// A DATA_W-bit frame is shifted out MSB first, one bit per 2*HALF clk cycles,
// with the serial clock rising mid-bit. All pin outputs come straight from flops.
// Optional feature macro: SEG_P2S_AUTO_REFRESH_EN (self-starting back-to-back
// frames; start is ignored when defined).
module seg_p2s #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned HALF   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done,
    output logic              s_clk,
    output logic              s_dat,
    output logic              s_clr,
    output logic              s_en
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned PH_W  = (2 * HALF > 1) ? $clog2(2 * HALF) : 1;

    localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(DATA_W - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * HALF - 1);
    localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(HALF);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]  bit_q,   bit_d;
    logic [PH_W-1:0]   phase_q, phase_d;

    logic busy_q,  busy_d;
    logic done_q,  done_d;
    logic s_clk_q, s_clk_d;
    logic s_dat_q, s_dat_d;
    logic s_clr_q;
    logic s_en_q,  s_en_d;

    logic go;

`ifdef SEG_P2S_AUTO_REFRESH_EN
    logic start_unused;
    assign start_unused = start;
    assign go = s_clr_q;
`else
    assign go = s_clr_q & start;
`endif

    // Frame sequencing: capture in IDLE, walk phase/bit counters in SHIFT, one DONE cycle.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_SHIFT;
                    shreg_d = data;
                    bit_d   = BIT_TOP;
                    phase_d = '0;
                end
            end
            ST_SHIFT: begin
                if (phase_q == PH_LAST) begin
                    phase_d = '0;
                    if (bit_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_d   = bit_q - 1'b1;
                        shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin values are derived from the next state so the registered pins line up with it.
    always_comb begin
        busy_d  = (state_d == ST_SHIFT);
        done_d  = (state_d == ST_DONE);
        s_clk_d = (state_d == ST_SHIFT) && (phase_d >= PH_HIGH);
        s_dat_d = (state_d == ST_SHIFT) && shreg_d[DATA_W-1];
        s_en_d  = s_en_q | done_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            phase_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_clk_q <= 1'b0;
            s_dat_q <= 1'b0;
            s_clr_q <= 1'b0;
            s_en_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            s_clk_q <= s_clk_d;
            s_dat_q <= s_dat_d;
            s_clr_q <= 1'b1;
            s_en_q  <= s_en_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign s_clk = s_clk_q;
    assign s_dat = s_dat_q;
    assign s_clr = s_clr_q;
    assign s_en  = s_en_q;

endmodule

// File: tb/tb_seg_p2s.sv
// tb_seg_p2s: scoreboard bench for seg_p2s with DATA_W=8, HALF=2.
module tb_seg_p2s;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned HALF   = 2;
    localparam int unsigned FRAME  = DATA_W * 2 * HALF;

    logic              clk;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] data;
    logic              busy, done, s_clk, s_dat, s_clr, s_en;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    seg_p2s #(.DATA_W(DATA_W), .HALF(HALF)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .busy  (busy),
        .done  (done),
        .s_clk (s_clk),
        .s_dat (s_dat),
        .s_clr (s_clr),
        .s_en  (s_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state (as seen after each rising edge).
    int unsigned cyc = 0;
    int unsigned m_state = 0;   // 0 idle, 1 shift, 2 done
    int unsigned m_left = 0;
    bit          m_clr = 1'b0;
    bit          m_en  = 1'b0;
    logic        bq[$];         // expected serial bits
    int unsigned dq[$];         // expected done cycles

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_state = 0;
                m_clr   = 1'b0;
                m_en    = 1'b0;
                bq.delete();
                dq.delete();
            end else begin
                case (m_state)
                    0: if (m_clr && start) begin
                        for (int i = DATA_W - 1; i >= 0; i--) bq.push_back(data[i]);
                        dq.push_back(cyc + FRAME);
                        m_state = 1;
                        m_left  = FRAME - 1;
                    end
                    1: if (m_left == 0) begin
                        m_state = 2;
                        m_en    = 1'b1;
                    end else begin
                        m_left--;
                    end
                    default: m_state = 0;
                endcase
                m_clr = 1'b1;
            end
        end
    end

    // Output monitor: compares pins against the model and pops the scoreboard.
    int unsigned rises = 0;
    int unsigned first_rise = 0;
    int unsigned last_start = 0;
    int unsigned starts[$];
    logic prev_sclk = 1'b0;
    logic prev_busy = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            chk("busy", busy, (m_state == 1) ? 32'd1 : 32'd0);
            chk("s_clr", s_clr, m_clr);
            chk("s_en", s_en, m_en);
            if (m_state != 1) begin
                chk("s_clk_quiet", s_clk, 0);
                chk("s_dat_quiet", s_dat, 0);
            end
            if (busy && !prev_busy) begin
                rises = 0;
                last_start = cyc;
                starts.push_back(cyc);
            end
            if (s_clk && !prev_sclk) begin
                rises++;
                if (rises == 1) first_rise = cyc;
                if (bq.size() == 0) chk("bit_avail", bq.size(), 1);
                else chk("bit", s_dat, bq.pop_front());
            end
            begin
                bit exp_done;
                exp_done = (dq.size() > 0) && (dq[0] == cyc);
                chk("done", done, exp_done);
                if (exp_done) begin
                    void'(dq.pop_front());
                    chk("rises", rises, DATA_W);
                    chk("bits_left", bq.size(), 0);
                    chk("first_rise", first_rise - last_start, HALF);
                end
            end
            prev_sclk = s_clk;
            prev_busy = busy;
        end
    end

    task automatic send(input logic [DATA_W-1:0] d);
        @(negedge clk);
        start = 1'b1;
        data  = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned lim);
        bit got = 1'b0;
        for (int unsigned i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", got, 1);
    endtask

    task automatic wait_busy(input int unsigned lim);
        bit got = 1'b0;
        for (int unsigned i = 0; i < lim; i++) begin
            @(negedge clk);
            if (busy) begin
                got = 1'b1;
                break;
            end
        end
        chk("busy_seen", got, 1);
    endtask

    int unsigned n0;
    bit          seen4;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {busy, done, s_clk, s_dat, s_clr, s_en}, 0);

        // Release reset with start already high: must be ignored while s_clr is low.
        rst   = 1'b0;
        start = 1'b1;
        data  = 8'hFF;
        #1 chk("clr_first", s_clr, 0);
        @(negedge clk);
        start = 1'b0;
        chk("clr_second", s_clr, 1);
        chk("busy_no_start", busy, 0);
        repeat (3) @(negedge clk);

        // Single frame with start/data disturbance mid-frame.
        send(8'hA5);
        repeat (6) @(negedge clk);
        start = 1'b1;
        data  = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_done(FRAME + 8);
        chk("s_en_with_done", s_en, 1);
        repeat (5) @(negedge clk);
        chk("no_restart", busy, 0);

        // Back-to-back frames with start held high.
        n0    = starts.size();
        start = 1'b1;
        data  = 8'h3C;
        wait_busy(4);
        data  = 8'hC3;
        wait_done(FRAME + 8);
        wait_busy(6);
        start = 1'b0;
        wait_done(FRAME + 8);
        chk("b2b_count", starts.size() - n0, 2);
        if (starts.size() >= n0 + 2) chk("b2b_gap", starts[n0+1] - starts[n0], FRAME + 2);
        repeat (4) @(negedge clk);

        // Abort a frame after the 4th serial-clock rise.
        send(8'h5A);
        seen4 = 1'b0;
        for (int unsigned i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (rises >= 4) begin
                seen4 = 1'b1;
                break;
            end
        end
        chk("rise4_seen", seen4, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_sclk", s_clk, 0);
        chk("abort_sdat", s_dat, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sen", s_en, 0);
        chk("abort_done", done, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Fresh frame after the abort.
        send(8'h96);
        wait_done(FRAME + 8);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
